// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle main controller for the 8-bit-opcode MIPS datapath.
//   It steps each instruction through fetch, decode, execute, memory and
//   writeback. It drives the ALU, PC, IR, register-file and memory control
//   lines, and handshakes with a variable-latency unified memory
//   (mem_req / mem_ready).
//
//   Ports
//     clk, reset         rising-edge clock, async active-high reset
//     opcode             IR opcode field, sampled only in DECODE
//     zero               ALU zero flag, used in BRANCH
//     mem_ready          memory completes the pending access this cycle
//     mem_req/mem_we/iord                   memory request, write, address select
//     irwrite/pcwrite/pcsrc                 IR and PC load controls
//     alusrca/alusrcb/aluop                 ALU operand and operation selects
//     regwrite/regdst/memtoreg/jfor         register-file write controls
//     instr_done/illegal                    one-cycle retire / bad-opcode pulses
//     state                                 current state (debug)
//     cycle_cnt/instr_cnt                   performance counters
//
//   Optional feature: define CTRL_PERF_EN to build the cycle and instruction
//   counters. When it is not defined, both counter ports are tied to 0.
module multicycle_control #(
  parameter int OP_BASE = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             jfor,
  output logic             instr_done,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] OP_R    = 8'(OP_BASE);
  localparam logic [7:0] OP_LW   = 8'(OP_BASE + 1);
  localparam logic [7:0] OP_SW   = 8'(OP_BASE + 2);
  localparam logic [7:0] OP_BEQ  = 8'(OP_BASE + 3);
  localparam logic [7:0] OP_BNE  = 8'(OP_BASE + 4);
  localparam logic [7:0] OP_ADDI = 8'(OP_BASE + 5);
  localparam logic [7:0] OP_J    = 8'(OP_BASE + 6);
  localparam logic [7:0] OP_JAL  = 8'(OP_BASE + 7);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_REXEC    = 4'd7,
    S_RWB      = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  state_t     st, nxt;
  logic [7:0] op_q;

  assign state = st;

  // Every output is decoded from st. An async reset therefore clears all
  // outputs at once, including mem_req and mem_we during a memory stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_IDLE;
    else       st <= nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                op_q <= 8'd0;
    else if (st == S_DECODE)  op_q <= opcode;
  end

  always_comb begin
    nxt = S_IDLE;
    case (st)
      S_IDLE:     nxt = S_FETCH;
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (opcode == OP_R)                        nxt = S_REXEC;
        else if (opcode == OP_LW  || opcode == OP_SW)   nxt = S_MEMADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE)  nxt = S_BRANCH;
        else if (opcode == OP_ADDI)                     nxt = S_IEXEC;
        else if (opcode == OP_J   || opcode == OP_JAL)  nxt = S_JUMP;
        else                                            nxt = S_ILLEGAL;
      end
      S_MEMADDR:  nxt = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_REXEC:    nxt = S_RWB;
      S_RWB:      nxt = S_FETCH;
      S_IEXEC:    nxt = S_IWB;
      S_IWB:      nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JUMP:     nxt = S_FETCH;
      S_ILLEGAL:  nxt = S_FETCH;
      default:    nxt = S_IDLE;   // 14/15 are unreachable; recover through IDLE
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    jfor       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (st)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;          // PC + 1
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE:   alusrcb = 2'b11;  // branch target into ALUOut
      S_MEMADDR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        instr_done = 1'b1;
        pcwrite    = ((op_q == OP_BEQ) &  zero) |
                     ((op_q == OP_BNE) & ~zero);
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        jfor       = (op_q == OP_JAL);
        regwrite   = (op_q == OP_JAL);
      end
      S_ILLEGAL:  illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (st != S_IDLE) cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done)   instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
